// File: rtl/msx_ce_gen.sv
// msx_ce_gen: multi-channel clock-enable generator with per-channel runtime
// divisors, boundary-aligned divisor updates, phase resync and a pause/ack
// handshake that drains every channel to a period boundary before freezing.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | all channels count and strobe
// DRAIN   | no strobes; each channel stops once its counter reaches 0
// PAUSED  | all counters held at 0, no strobes, pause_ack high
module msx_ce_gen #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    resync_i,
    input  logic                    pause_req,
    output logic                    pause_ack,
    output logic [NUM_CH-1:0]       ce_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] cnt [NUM_CH];
    logic [DIV_W-1:0] div_act [NUM_CH];
    logic [NUM_CH-1:0] stopped;
    logic [NUM_CH-1:0] at_zero;
    logic [NUM_CH-1:0] at_end;
    logic [NUM_CH-1:0] stop_now;
    logic              all_stop;

    // Per-channel boundary flags; a channel counts as stopped as soon as it
    // sits at 0 during DRAIN, so PAUSED can be entered on that same edge.
    always_comb begin
        at_zero = '0;
        at_end  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            at_zero[k] = (cnt[k] == '0);
            at_end[k]  = (cnt[k] == div_act[k]);
        end
        stop_now = stopped | at_zero;
        all_stop = &stop_now;
    end

    // Global pause FSM next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (pause_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pause_req)   state_nxt = ST_RUN;
                else if (all_stop) state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!pause_req) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM, counters, shadow divisors, stopped flags and registered strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            pause_ack <= 1'b0;
            ce_o      <= '0;
            stopped   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]     <= '0;
                div_act[k] <= div_i[k*DIV_W +: DIV_W];
            end
        end else begin
            state     <= state_nxt;
            pause_ack <= (state_nxt == ST_PAUSED);

            // Leaving DRAIN/PAUSED releases every channel from 0.
            if (state_nxt == ST_RUN)
                stopped <= '0;
            else if (state == ST_DRAIN)
                stopped <= stop_now;

            for (int k = 0; k < NUM_CH; k++) begin
                if (resync_i) begin
                    cnt[k]     <= '0;
                    div_act[k] <= div_i[k*DIV_W +: DIV_W];
                    ce_o[k]    <= 1'b0;
                end else begin
                    case (state)
                        ST_RUN: begin
                            ce_o[k] <= at_zero[k];
                            if (at_end[k]) begin
                                cnt[k]     <= '0;
                                div_act[k] <= div_i[k*DIV_W +: DIV_W];
                            end else begin
                                cnt[k] <= cnt[k] + DIV_W'(1);
                            end
                        end
                        ST_DRAIN: begin
                            ce_o[k] <= 1'b0;
                            if (stop_now[k]) begin
                                cnt[k] <= '0;
                            end else if (at_end[k]) begin
                                cnt[k]     <= '0;
                                div_act[k] <= div_i[k*DIV_W +: DIV_W];
                            end else begin
                                cnt[k] <= cnt[k] + DIV_W'(1);
                            end
                        end
                        default: begin
                            ce_o[k] <= 1'b0;
                            cnt[k]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_msx_ce_gen.sv
// Directed bench for msx_ce_gen (NUM_CH=3, DIV_W=4) with hand-computed strobes.
module tb_msx_ce_gen;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic                    resync_i;
    logic                    pause_req;
    logic                    pause_ack;
    logic [NUM_CH-1:0]       ce_o;

    int vectors     = 0;
    int miscompares = 0;
    int n0, n1, n2;

    msx_ce_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .div_i     (div_i),
        .resync_i  (resync_i),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .ce_o      (ce_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        resync_i  = 1'b0;
        pause_req = 1'b0;
        div_i     = {4'd7, 4'd3, 4'd1};
        tick();
        tick();
        chk("reset_ce", 32'(ce_o), 32'd0);
        chk("reset_ack", 32'(pause_ack), 32'd0);

        // Release reset: all strobe together, then periods 2/4/8.
        reset_n = 1'b1;
        n0 = 0; n1 = 0; n2 = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            chk("cadence", 32'(ce_o), 32'({(j % 8) == 0, (j % 4) == 0, (j % 2) == 0}));
            n0 += int'(ce_o[0]);
            n1 += int'(ce_o[1]);
            n2 += int'(ce_o[2]);
        end
        chk("count_ch0", n0, 32);
        chk("count_ch1", n1, 16);
        chk("count_ch2", n2, 8);

        // ch1 divisor 3 -> 5 two clocks after a strobe: boundary keeps 4, then 6.
        for (int j = 0; j <= 16; j++) begin
            tick();
            if (j == 2) div_i = {4'd7, 4'd5, 4'd1};
            chk("div_change", 32'(ce_o),
                32'({(j % 8) == 0, (j == 0 || j == 4 || j == 10 || j == 16), (j % 2) == 0}));
        end

        // Bring ch2 to cnt=3, then request pause.
        tick();
        chk("pre_pause_a", 32'(ce_o), 32'b000);
        tick();
        chk("pre_pause_b", 32'(ce_o), 32'b001);
        pause_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("drain", 32'({pause_ack, ce_o}), (k == 5) ? 32'b1000 : 32'b0000);
        end
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("paused_hold", 32'({pause_ack, ce_o}), 32'b1000);
        end
        pause_req = 1'b0;
        tick();
        chk("unpause_edge", 32'({pause_ack, ce_o}), 32'b0000);
        tick();
        chk("unpause_strobe", 32'({pause_ack, ce_o}), 32'b0111);

        // Resync mid-period; ch1 divisor goes back to 3 through the resync reload.
        tick();
        chk("post_resume_1", 32'(ce_o), 32'b000);
        tick();
        chk("post_resume_2", 32'(ce_o), 32'b001);
        tick();
        chk("post_resume_3", 32'(ce_o), 32'b000);
        resync_i = 1'b1;
        div_i    = {4'd7, 4'd3, 4'd1};
        tick();
        chk("resync_quiet", 32'(ce_o), 32'b000);
        resync_i = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            chk("resync_cadence", 32'(ce_o), 32'({(j % 8) == 0, (j % 4) == 0, (j % 2) == 0}));
        end

        // ch0 divisor 0: continuous enable after its next boundary.
        div_i = {4'd7, 4'd3, 4'd0};
        for (int j = 16; j < 24; j++) begin
            tick();
            chk("div_zero", 32'(ce_o), 32'({(j % 8) == 0, (j % 4) == 0, j != 17}));
        end
        pause_req = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            chk("drain_div0", 32'({pause_ack, ce_o}),
                (k == 0) ? 32'b0111 : ((k == 8) ? 32'b1000 : 32'b0000));
        end

        // Reset while paused with pause_req held high.
        tick();
        chk("paused_pre_reset", 32'({pause_ack, ce_o}), 32'b1000);
        reset_n = 1'b0;
        tick();
        chk("reset_in_pause", 32'({pause_ack, ce_o}), 32'b0000);
        reset_n = 1'b1;
        tick();
        chk("post_reset_strobe", 32'({pause_ack, ce_o}), 32'b0111);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("redrain", 32'({pause_ack, ce_o}), (k == 8) ? 32'b1000 : 32'b0000);
        end

        pause_req = 1'b0;
        tick();
        chk("final_unpause", 32'({pause_ack, ce_o}), 32'b0000);
        tick();
        chk("final_strobe", 32'({pause_ack, ce_o}), 32'b0111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msx_ce_gen.md
# msx_ce_gen

Parametrised multi-channel clock-enable generator for the MSX core family, replacing the fixed divide-by-4/divide-by-8 enable logic in the system top. It produces NUM_CH single-cycle enable strobes from one system clock, each with a runtime-programmable divisor. It also supports glitch-free divisor changes, a forced phase resync, and a pause/ack handshake that drains every channel to a period boundary, so the whole machine can be frozen cleanly (OSD pause, savestates).

## Interface
- NUM_CH, 3: number of enable channels (1..8).
- DIV_W, 4: width of each divisor field; maximum period is 2^DIV_W clocks.
- clk  in  1: system clock; all logic on its rising edge.
- reset_n  in  1: synchronous, active-low reset.
- div_i  in  NUM_CH*DIV_W: per-channel divisor minus one. Channel k uses bits [k*DIV_W +: DIV_W]. Period is div+1 clocks.
- resync_i  in  1: single-cycle request to realign all channels.
- pause_req  in  1: level; high requests a frozen state.
- pause_ack  out  1: high while fully paused.
- ce_o  out  NUM_CH: per-channel enable strobes, registered.

## Operation
- Per channel k:
  - Counter cnt_k is DIV_W bits. Active divisor d_k is a DIV_W-bit shadow register.
  - Running channel: ce_o[k] <= (cnt_k == 0). cnt_k <= (cnt_k == d_k) ? 0 : cnt_k + 1.
  - On the edge where cnt_k == d_k, d_k <= div_i slice k. A new divisor therefore takes effect only at a period boundary, and no period is ever truncated or stretched mid-way.
  - d_k == 0 gives ce_o[k] high every cycle while running.
- Global FSM states RUN, DRAIN, PAUSED:
  - RUN: all channels run. If pause_req = 1 → DRAIN.
  - DRAIN: a channel whose cnt_k == 0 sets its stopped flag, holds cnt_k = 0, and issues no strobe. Other channels keep counting.
  - DRAIN → PAUSED when all stopped flags are set, including on the entry edge.
  - DRAIN → RUN if pause_req = 0. All stopped flags clear on that edge, and stopped channels resume from cnt = 0.
  - PAUSED: ce_o = 0, counters held at 0, pause_ack = 1. pause_req = 0 → RUN.
- Resync (resync_i = 1 on an edge):
  - All cnt_k <= 0, all d_k <= div_i, ce_o <= 0 for that edge.
  - In RUN, every channel then strobes together on the following edge.
  - In DRAIN, every channel is at 0 and therefore stops. In PAUSED, state is unchanged apart from the reloaded divisors.
- Priority: reset_n low > resync_i > normal counting.

## Timing
- Reset (reset_n = 0 at an edge):
  - ce_o = 0, pause_ack = 0, FSM = RUN, all cnt_k = 0, stopped flags clear.
  - d_k <= div_i on every reset edge.
- First strobe: all channels assert ce_o in the cycle after the first edge with reset_n = 1. Channel k then repeats every d_k + 1 clocks.
- Strobe latency: ce_o[k] is high in the cycle after the edge at which cnt_k was 0. Pulse width is exactly one clk.
- pause_ack rises on the edge the FSM enters PAUSED. Latency from pause_req is 1 clock plus the longest remaining partial period, max 2^DIV_W clocks.
- pause_ack falls on the edge pause_req is sampled low. The first strobes on all channels appear one cycle after that edge.
- ce_o is 0 in the first cycle after entering PAUSED.
- Divisor changes on div_i outside a boundary edge have no effect until the boundary. Glitches between boundaries are ignored.
- reset_n low mid-DRAIN or mid-PAUSED: FSM returns to RUN and pause_ack drops after that edge. If pause_req is still high, DRAIN re-enters on the first post-reset edge.
- resync_i and pause_req rising on the same edge: resync applies and the FSM enters DRAIN. All channels are at 0, so PAUSED follows on the next edge.

## Test plan
- NUM_CH=3, DIV_W=4, div = {7,3,1} (ch2,ch1,ch0). Release reset:
  - all three strobe together one cycle later;
  - ch0 then strobes every 2 clocks, ch1 every 4, ch2 every 8;
  - over 64 clocks the counts are 32, 16 and 8.
- ch1 at period 4: change div_i slice 1 from 3 to 5 two clocks after a strobe → the next strobe is still 4 clocks after the previous one, and subsequent strobes are every 6 clocks.
- Running, with ch2 cnt = 3 and d = 7: assert pause_req → ch2 runs out its 5 remaining counts with no further strobes after boundaries. pause_ack rises once all channels are stopped, within 8 clocks, and ce_o = 0 for 100 clocks. Deassert pause_req → pause_ack low after the edge, and all channels strobe together one cycle later.
- Pulse resync_i mid-period with div = {7,3,1} → ce_o = 0 for one cycle, then all three strobe on the same cycle, then return to the nominal cadence.
- d = 0 on ch0 → ce_o[0] is continuously high. Assert pause_req → PAUSED is reached no earlier than the other channels' boundaries, and ce_o[0] is 0 while DRAIN waits on the other channels.
- Assert reset_n = 0 for 1 clock while PAUSED, with pause_req held high → pause_ack = 0 and ce_o = 0 after the reset edge, strobes resume the next cycle, and PAUSED is re-entered after the drain.
